// File: rtl/decimal_entry_if.sv
// Key-entry and conversion-result signals shared between a keypad source and decimal_entry.
interface decimal_entry_if #(
  parameter int NUM_DIGITS = 8,
  parameter int WIDTH      = 32
);
  logic                      key_valid;
  logic [3:0]                key_code;
  logic                      key_ready;
  logic                      busy;
  logic [3:0]                digit_count;
  logic                      entry_full;
  logic [4*NUM_DIGITS-1:0]   bcd_digits;
  logic [WIDTH-1:0]          result;
  logic                      result_valid;

  modport master (
    output key_valid, key_code,
    input  key_ready, busy, digit_count, entry_full, bcd_digits, result, result_valid
  );

  modport slave (
    input  key_valid, key_code,
    output key_ready, busy, digit_count, entry_full, bcd_digits, result, result_valid
  );
endinterface

// File: rtl/decimal_entry.sv
// Keypad decimal entry buffer with packed-BCD display and serial BCD-to-binary conversion.
// state   | meaning
// IDLE    | accepting digit/backspace/clear/enter keys
// CONVERT | one BCD digit folded into acc per cycle, MSD first; then result is latched
// DONE    | result_valid pulse; entry cleared on exit
module decimal_entry #(
  parameter int NUM_DIGITS = 8,
  parameter int WIDTH      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  decimal_entry_if.slave  bus
);
  localparam int         BCD_W   = 4 * NUM_DIGITS;
  localparam logic [3:0] MAX_CNT = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  state_t             state, state_nxt;
  logic [BCD_W-1:0]   bcd_q;
  logic [BCD_W-1:0]   shreg;
  logic [3:0]         count;
  logic [3:0]         step;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   result_q;
  logic               accept;

  assign accept = bus.key_valid && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // One extra CONVERT cycle after the last fold latches acc into result.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && bus.key_code == 4'hC) state_nxt = CONVERT;
      CONVERT: if (step == MAX_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.key_ready    = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.result_valid = (state == DONE);
    bus.digit_count  = count;
    bus.entry_full   = (count == MAX_CNT);
    bus.bcd_digits   = bcd_q;
    bus.result       = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q    <= '0;
      shreg    <= '0;
      count    <= '0;
      step     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.key_code <= 4'd9) begin
              if (count != MAX_CNT) begin
                bcd_q <= {bcd_q[BCD_W-5:0], bus.key_code};
                count <= count + 4'd1;
              end
            end else if (bus.key_code == 4'hA) begin
              if (count != 4'd0) begin
                bcd_q <= {4'h0, bcd_q[BCD_W-1:4]};
                count <= count - 4'd1;
              end
            end else if (bus.key_code == 4'hB) begin
              bcd_q <= '0;
              count <= '0;
            end else if (bus.key_code == 4'hC) begin
              shreg <= bcd_q;
              acc   <= '0;
              step  <= '0;
            end
          end
        end
        CONVERT: begin
          if (step != MAX_CNT) begin
            acc   <= (acc << 3) + (acc << 1) + {{(WIDTH-4){1'b0}}, shreg[BCD_W-1 -: 4]};
            shreg <= shreg << 4;
            step  <= step + 4'd1;
          end else begin
            result_q <= acc;
          end
        end
        DONE: begin
          bcd_q <= '0;
          count <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_decimal_entry.sv
// Directed keypad sequences; expected conversion results are queued and checked by a monitor.
module tb_decimal_entry;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decimal_entry_if #(.NUM_DIGITS(8), .WIDTH(32)) bus ();
  decimal_entry #(.NUM_DIGITS(8), .WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  int cyc = 0;
  int enter_cyc = 0;
  logic prev_rv = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 2ns after a rising edge, so the falling edge sees what the next edge accepts.
  always @(negedge clk) begin
    cyc++;
    if (bus.key_valid && bus.key_ready && bus.key_code == 4'hC) enter_cyc = cyc;
    if (bus.result_valid) begin
      if (prev_rv) check("rv_single_pulse", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 32'd1, 32'd0);
      end else begin
        check("result", bus.result, exp_q.pop_front());
        check("latency", 32'(cyc - enter_cyc), 32'd10);
      end
    end
    prev_rv = bus.result_valid;
  end

  task automatic press(input logic [3:0] code);
    @(posedge clk); #2;
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    @(posedge clk); #2;
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.key_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("wait_idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_result_valid", 32'(bus.result_valid), 32'd0);
    check("rst_count", 32'(bus.digit_count), 32'd0);
    check("rst_key_ready", 32'(bus.key_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);

    for (int d = 1; d <= 8; d++) press(4'(d));
    check("bcd_12345678", bus.bcd_digits, 32'h1234_5678);
    check("count_8", 32'(bus.digit_count), 32'd8);
    exp_q.push_back(32'd12345678);
    press(4'hC);
    wait_idle();
    check("count_after_conv", 32'(bus.digit_count), 32'd0);
    check("bcd_after_conv", bus.bcd_digits, 32'd0);

    for (int d = 0; d < 9; d++) press(4'h9);
    check("bcd_nines", bus.bcd_digits, 32'h9999_9999);
    check("count_nines", 32'(bus.digit_count), 32'd8);
    check("entry_full", 32'(bus.entry_full), 32'd1);
    exp_q.push_back(32'd99999999);
    press(4'hC);
    wait_idle();

    press(4'h4); press(4'h2); press(4'hA); press(4'h7);
    check("bcd_47", bus.bcd_digits, 32'h47);
    check("count_47", 32'(bus.digit_count), 32'd2);
    exp_q.push_back(32'd47);
    press(4'hC);
    wait_idle();

    press(4'hA);
    check("bksp_at_0_bcd", bus.bcd_digits, 32'd0);
    check("bksp_at_0_count", 32'(bus.digit_count), 32'd0);
    press(4'h3); press(4'h5); press(4'hE);
    check("bcd_35_ignore_E", bus.bcd_digits, 32'h35);
    press(4'hB);
    check("clear_bcd", bus.bcd_digits, 32'd0);
    check("clear_count", 32'(bus.digit_count), 32'd0);

    exp_q.push_back(32'd0);
    press(4'hC);
    wait_idle();

    press(4'h1); press(4'h2);
    exp_q.push_back(32'd12);
    press(4'hC);
    press(4'h9);
    check("busy_in_convert", 32'(bus.busy), 32'd1);
    check("bcd_held_busy", bus.bcd_digits, 32'h12);
    check("count_held_busy", 32'(bus.digit_count), 32'd2);
    wait_idle();
    check("count_after_busy_key", 32'(bus.digit_count), 32'd0);
    check("result_held", bus.result, 32'd12);

    press(4'h6);
    press(4'hC);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_result", bus.result, 32'd0);
    check("abort_result_valid", 32'(bus.result_valid), 32'd0);
    check("abort_key_ready", 32'(bus.key_ready), 32'd1);
    check("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_result_later", bus.result, 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/decimal_entry.md
DECIMAL_ENTRY -- requirements
Module: decimal_entry

Interface
REQ-001 Parameter NUM_DIGITS, default 8: maximum decimal digits held; only 8 is required and verified.
REQ-002 Parameter WIDTH, default 32: binary result width.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 key_valid  input  1  key event strobe; accepted only when key_valid && key_ready at a rising edge.
REQ-007 key_code  input  4  0-9 digit; 4'hA backspace; 4'hB clear; 4'hC enter; 4'hD-4'hF ignored.
REQ-008 key_ready  output  1  high only in IDLE.
REQ-009 busy  output  1  high in CONVERT and DONE.
REQ-010 digit_count  output  4  digits currently entered, 0..8.
REQ-011 entry_full  output  1  digit_count == 8.
REQ-012 bcd_digits  output  32  current entry, packed BCD, least significant digit in [3:0], unused digits zero.
REQ-013 result  output  WIDTH  binary value of the last converted entry; held until the next conversion completes.
REQ-014 result_valid  output  1  one-cycle pulse marking a new result.

Function
REQ-015 The FSM SHALL have states IDLE, CONVERT and DONE.
REQ-016 IDLE, digit accepted with count < 8: bcd_digits <= {bcd_digits[27:0], digit}; count += 1.
REQ-017 IDLE, digit accepted with count == 8: digit dropped; no state change.
REQ-018 IDLE, backspace: bcd_digits <= {4'h0, bcd_digits[31:4]}; count -= 1; no-op at count 0.
REQ-019 IDLE, clear: bcd_digits <= 0; count <= 0.
REQ-020 IDLE, enter: copy bcd_digits into an internal conversion shift register; acc <= 0; step <= 0; next state CONVERT. Enter at count 0 SHALL still convert, giving 0.
REQ-021 IDLE, codes D-F: no effect.
REQ-022 While key_ready is low, keys SHALL be dropped without buffering; the source re-presents them after key_ready returns.
REQ-023 CONVERT, each cycle: acc <= (acc<<3) + (acc<<1) + shreg[31:28]; shreg <= shreg << 4; step += 1.
REQ-024 All CONVERT arithmetic SHALL be WIDTH bits and truncating. The maximum value 99,999,999 fits in 27 bits, so no overflow occurs.
REQ-025 After exactly 8 CONVERT cycles the next state SHALL be DONE.
REQ-026 DONE lasts one cycle:
- result_valid = 1.
- result holds the final acc, registered on the edge entering DONE.
- bcd_digits and count clear on the edge leaving DONE.
- next state is IDLE.
REQ-027 Latency: enter accepted at edge E; CONVERT spans E+1..E+8; result and result_valid update at edge E+9; key_ready returns high at edge E+10.
REQ-028 Digits SHALL be weighted MSD first; unentered leading digits are zero and contribute nothing.
REQ-029 bcd_digits SHALL remain visible and unchanged during CONVERT.

Reset
REQ-030 On rst_n low, immediately and asynchronously:
- state = IDLE.
- bcd_digits, count, acc, shift register, step and result = 0.
- result_valid = 0, busy = 0.
- key_ready = 1 once the FSM is in IDLE.
REQ-031 Reset during CONVERT or DONE SHALL abort the conversion: no result_valid pulse, and result reads 0.

Verification
REQ-032 Reset release -> result = 0, result_valid = 0, digit_count = 0, key_ready = 1, busy = 0.
REQ-033 Keys 1,2,3,4,5,6,7,8 then enter:
- bcd_digits = 0x12345678 before enter.
- result = 12345678 (0x00BC614E) with a single result_valid pulse 9 edges after enter.
- digit_count = 0 afterwards.
REQ-034 Nine digit-9 keys then enter:
- 9th key dropped; entry_full = 1.
- result = 99999999 (0x05F5E0FF).
REQ-035 Keys 4,2,backspace,7,enter -> result = 47.
REQ-036 Backspace at count 0 -> no change. Clear after 3,5 -> bcd_digits = 0.
REQ-037 Enter at count 0 -> result = 0 with a result_valid pulse. Digit keys during busy -> dropped; bcd_digits unchanged.
REQ-038 rst_n low in CONVERT cycle 4 -> no result_valid pulse, result = 0, state IDLE.
